// File: rtl/risc16_mem_pkg.sv
// Shared types and address helpers for the risc16 memory subsystem.
// No ports; imported by the interface, the read pipe and the top.
package risc16_mem_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    typedef enum logic {
        LANE_EVEN = 1'b0,
        LANE_ODD  = 1'b1
    } lane_e;

    localparam logic [15:0] IO_BASE_DEF = 16'h0200;

    function automatic logic [31:0] even_addr(input logic [31:0] a);
        return a & ~32'd1;
    endfunction

    function automatic logic [31:0] odd_addr(input logic [31:0] a);
        return a | 32'd1;
    endfunction

    function automatic logic [31:0] lane_addr(input logic [31:0] a, input lane_e lane);
        return (lane == LANE_ODD) ? odd_addr(a) : even_addr(a);
    endfunction

    // True when byte address b falls inside the I/O channel window.
    function automatic logic in_io(input logic [31:0] b, input logic [31:0] base,
                                   input logic [31:0] ch);
        return (b >= base) && (b < base + ch);
    endfunction

endpackage

// File: rtl/risc16_mem_sys_if.sv
// Instruction/data bus bundle of the risc16 memory subsystem.
// master: CPU side (drives addresses, requests, write data/enables).
// slave : memory side (drives read words, valid strobes, I/O channels).
interface risc16_mem_sys_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IO_CH  = 4
);
    import risc16_mem_pkg::*;

    logic [ADDR_W-1:0]  iaddr;
    logic               ioe;
    word_t              idin;
    logic               ivalid;
    logic [ADDR_W-1:0]  daddr;
    word_t              ddout;
    logic               doe;
    logic               dwe0;
    logic               dwe1;
    word_t              ddin;
    logic               dvalid;
    logic [IO_CH*8-1:0] io_out;

    modport master (
        output iaddr, ioe, daddr, ddout, doe, dwe0, dwe1,
        input  idin, ivalid, ddin, dvalid, io_out
    );

    modport slave (
        input  iaddr, ioe, daddr, ddout, doe, dwe0, dwe1,
        output idin, ivalid, ddin, dvalid, io_out
    );

endinterface

// File: rtl/risc16_rd_pipe.sv
// RD_LAT-deep delay line for one read port carrying {valid, word}.
// Ports: clk, rst (sync, active-high flush), in_valid/in_word (accepted read),
//        out_valid/out_word (strobe and word; word holds while strobe is low).
module risc16_rd_pipe
    import risc16_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  word_t in_word,
    output logic  out_valid,
    output word_t out_word
);

    logic [RD_LAT-1:0]  vld_q, vld_d;
    word_t [RD_LAT-1:0] wrd_q, wrd_d;
    logic [RD_LAT:0]    vchain;
    word_t [RD_LAT:0]   wchain;

    // Each stage loads from the one before it; words only move with a valid,
    // so the last stage naturally holds the previous result.
    always_comb begin
        vchain = {vld_q, in_valid};
        wchain = {wrd_q, in_word};
        vld_d  = '0;
        wrd_d  = wrd_q;
        for (int s = 0; s < int'(RD_LAT); s++) begin
            vld_d[s] = vchain[s];
            wrd_d[s] = vchain[s] ? wchain[s] : wrd_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            wrd_q <= '0;
        end else begin
            vld_q <= vld_d;
            wrd_q <= wrd_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_word  = wrd_q[RD_LAT-1];

endmodule

// File: rtl/risc16_mem_sys.sv
// Byte-addressed unified memory with memory-mapped 8-bit I/O channels.
// Ports: clk, rst (sync, active-high), bus (slave side of risc16_mem_sys_if):
//        instruction read port, data read/write port with big-endian lanes,
//        and the io_out channel registers.
module risc16_mem_sys
    import risc16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned IO_BASE   = 32'(IO_BASE_DEF),
    parameter int unsigned IO_CH     = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    risc16_mem_sys_if.slave   bus
);

    localparam int unsigned MW   = $clog2(MEM_BYTES);
    localparam int unsigned CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;

    byte_t             mem [MEM_BYTES];
    byte_t [IO_CH-1:0] io_q, io_d;

    logic [ADDR_W-1:0] ia_c, da_c;
    logic [31:0]       wa_even_c, wa_odd_c;
    logic              mem_we_even_c, mem_we_odd_c;
    word_t             iword_c, dword_c;

    assign ia_c = bus.iaddr;
    assign da_c = bus.daddr;

    // One byte as seen by a read: I/O window shadows memory, upper address
    // bits beyond the memory size wrap.
    function automatic byte_t rd_byte(input logic [31:0] b);
        if (in_io(b, IO_BASE, IO_CH)) begin
            return io_q[CH_W'(b - IO_BASE)];
        end
        return mem[MW'(b)];
    endfunction

    // Read words are sampled from current state, so same-cycle writes are not seen.
    always_comb begin
        iword_c = {rd_byte(lane_addr(32'(ia_c), LANE_EVEN)),
                   rd_byte(lane_addr(32'(ia_c), LANE_ODD))};
        dword_c = {rd_byte(lane_addr(32'(da_c), LANE_EVEN)),
                   rd_byte(lane_addr(32'(da_c), LANE_ODD))};
    end

    // Per-lane write decode: each lane goes to either an I/O channel or memory.
    always_comb begin
        wa_even_c     = lane_addr(32'(da_c), LANE_EVEN);
        wa_odd_c      = lane_addr(32'(da_c), LANE_ODD);
        mem_we_even_c = bus.dwe0 && !rst && !in_io(wa_even_c, IO_BASE, IO_CH);
        mem_we_odd_c  = bus.dwe1 && !rst && !in_io(wa_odd_c, IO_BASE, IO_CH);
        io_d          = io_q;
        if (bus.dwe0 && in_io(wa_even_c, IO_BASE, IO_CH)) begin
            io_d[CH_W'(wa_even_c - IO_BASE)] = bus.ddout[15:8];
        end
        if (bus.dwe1 && in_io(wa_odd_c, IO_BASE, IO_CH)) begin
            io_d[CH_W'(wa_odd_c - IO_BASE)] = bus.ddout[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_q <= '0;
        end else begin
            io_q <= io_d;
        end
    end

    // Memory array has no reset; writes are already gated off during rst.
    always_ff @(posedge clk) begin
        if (mem_we_even_c) begin
            mem[MW'(wa_even_c)] <= bus.ddout[15:8];
        end
        if (mem_we_odd_c) begin
            mem[MW'(wa_odd_c)] <= bus.ddout[7:0];
        end
    end

    assign bus.io_out = io_q;

    risc16_rd_pipe #(.RD_LAT(RD_LAT)) u_ipipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.ioe),
        .in_word   (iword_c),
        .out_valid (bus.ivalid),
        .out_word  (bus.idin)
    );

    risc16_rd_pipe #(.RD_LAT(RD_LAT)) u_dpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.doe),
        .in_word   (dword_c),
        .out_valid (bus.dvalid),
        .out_word  (bus.ddin)
    );

endmodule

// File: tb/tb_risc16_mem_sys.sv
// Scoreboard bench for risc16_mem_sys: byte-level reference memory/I/O model,
// expected read words queued at issue and checked by an independent monitor.
module tb_risc16_mem_sys;
    import risc16_mem_pkg::*;

    localparam int unsigned MEMB = 1024;
    localparam int unsigned IOB  = 32'h200;
    localparam int unsigned IOCH = 4;
    localparam int unsigned LAT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc16_mem_sys_if #(.ADDR_W(16), .IO_CH(IOCH)) bus ();

    risc16_mem_sys #(
        .ADDR_W    (16),
        .MEM_BYTES (MEMB),
        .IO_BASE   (IOB),
        .IO_CH     (IOCH),
        .RD_LAT    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] w;
        int          due;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [7:0]  mm  [MEMB];
    logic [7:0]  mio [IOCH];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic        mon_en = 1'b0;
    logic [15:0] last_i = '0;
    logic [15:0] last_d = '0;

    function automatic logic in_win(input int unsigned a);
        return (a >= IOB) && (a < IOB + IOCH);
    endfunction

    function automatic logic [7:0] mbyte(input int unsigned a);
        if (in_win(a)) return mio[a - IOB];
        return mm[a % MEMB];
    endfunction

    function automatic logic [15:0] mword(input int unsigned a);
        return {mbyte(a & ~32'd1), mbyte(a | 32'd1)};
    endfunction

    task automatic mwrite(input int unsigned a, input logic [7:0] v);
        if (in_win(a)) mio[a - IOB] = v;
        else           mm[a % MEMB] = v;
    endtask

    function automatic logic [31:0] mio_packed();
        logic [31:0] p;
        for (int k = 0; k < int'(IOCH); k++) p[8*k +: 8] = mio[k];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive at negedge and advance the reference model.
    task automatic step(input logic r, input logic io, input logic [15:0] ia,
                        input logic d_o, input logic [15:0] da, input logic [15:0] dd,
                        input logic w0, input logic w1);
        @(negedge clk);
        rst = r; bus.ioe = io; bus.iaddr = ia; bus.doe = d_o; bus.daddr = da;
        bus.ddout = dd; bus.dwe0 = w0; bus.dwe1 = w1;
        if (r) begin
            iq.delete(); dq.delete();
            last_i = '0; last_d = '0;
            for (int k = 0; k < int'(IOCH); k++) mio[k] = '0;
        end else begin
            if (io)  iq.push_back('{mword(32'(ia)), cyc + int'(LAT)});
            if (d_o) dq.push_back('{mword(32'(da)), cyc + int'(LAT)});
            if (w0)  mwrite(32'(da) & ~32'd1, dd[15:8]);
            if (w1)  mwrite(32'(da) | 32'd1, dd[7:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: pop and compare whenever a strobe appears; flag late/missing ones.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                if (bus.ivalid) begin
                    if (iq.size() == 0) begin
                        chk("ivalid_unexpected", 32'(bus.ivalid), 32'd0);
                    end else begin
                        e = iq.pop_front();
                        chk("idin", 32'(bus.idin), 32'(e.w));
                        chk("ivalid_latency", 32'(cyc), 32'(e.due));
                        last_i = e.w;
                    end
                end else if (iq.size() > 0 && iq[0].due <= cyc) begin
                    e = iq.pop_front();
                    chk("ivalid_missing", 32'(bus.ivalid), 32'd1);
                end
                if (bus.dvalid) begin
                    if (dq.size() == 0) begin
                        chk("dvalid_unexpected", 32'(bus.dvalid), 32'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("ddin", 32'(bus.ddin), 32'(e.w));
                        chk("dvalid_latency", 32'(cyc), 32'(e.due));
                        last_d = e.w;
                    end
                end else if (dq.size() > 0 && dq[0].due <= cyc) begin
                    e = dq.pop_front();
                    chk("dvalid_missing", 32'(bus.dvalid), 32'd1);
                end
                chk("idin_hold", 32'(bus.idin), 32'(last_i));
                chk("ddin_hold", 32'(bus.ddin), 32'(last_d));
                chk("io_out", bus.io_out, mio_packed());
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1;
        bus.ioe = 1'b0; bus.iaddr = '0; bus.doe = 1'b0; bus.daddr = '0;
        bus.ddout = '0; bus.dwe0 = 1'b0; bus.dwe1 = 1'b0;

        repeat (3) step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rst_ivalid", 32'(bus.ivalid), 32'd0);
        chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
        chk("rst_idin",   32'(bus.idin),   32'd0);
        chk("rst_ddin",   32'(bus.ddin),   32'd0);
        chk("rst_io_out", bus.io_out,      32'd0);
        mon_en = 1'b1;

        // Known memory image; window addresses reach their bytes via the alias.
        for (int a = 0; a < int'(MEMB); a += 2) begin
            ra = (a >= int'(IOB) && a < int'(IOB + IOCH)) ? 16'(a + int'(MEMB)) : 16'(a);
            step(1'b0, 1'b0, '0, 1'b0, ra, 16'($urandom), 1'b1, 1'b1);
        end

        // Byte-lane write then odd-address read
        step(1'b0, 1'b0, '0, 1'b0, 16'h0010, 16'hABCD, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 16'h0011, '0, 1'b0, 1'b0);
        idle(int'(LAT));
        chk("lane_rd", 32'(bus.ddin), 32'h0000ABCD);

        // Split I/O write, then the shadowed memory bytes through the alias
        step(1'b0, 1'b0, '0, 1'b0, 16'h0200, 16'h5A00, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 16'h0203, 16'h003C, 1'b0, 1'b1);
        idle(1);
        chk("io_split", bus.io_out, 32'h3C00005A);
        step(1'b0, 1'b1, 16'h0202, 1'b1, 16'h0600, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'h0602, '0, 1'b0, 1'b0);
        idle(int'(LAT));

        // Read-before-write collision on the instruction port
        step(1'b0, 1'b0, '0, 1'b0, 16'h0020, 16'h1234, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 16'hBEEF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0020, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(int'(LAT) - 1);
        chk("collide_old", 32'(bus.idin), 32'h00001234);
        idle(1);
        chk("collide_new", 32'(bus.idin), 32'h0000BEEF);

        // Back-to-back reads
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1, 16'(2 * k), '0, 1'b0, 1'b0);
        idle(int'(LAT) + 1);

        // Reset while a read is in flight
        step(1'b0, 1'b0, '0, 1'b1, 16'h0008, '0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        chk("midrst_ddin",   32'(bus.ddin),   32'd0);
        chk("midrst_io_out", bus.io_out,      32'd0);
        idle(int'(LAT) + 2);
        chk("midrst_dvalid", 32'(bus.dvalid), 32'd0);

        // Upper address bits wrap
        step(1'b0, 1'b0, '0, 1'b0, 16'h0404, 16'h7777, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 16'h0004, '0, 1'b0, 1'b0);
        idle(int'(LAT));
        chk("alias", 32'(bus.ddin), 32'h00007777);

        // Random traffic biased toward the I/O window and a small hot region
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'(IOB + $urandom_range(0, 7));
                1:       ra = 16'($urandom_range(0, 63));
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 1) == 0) ? ra : 16'($urandom_range(0, 63));
            step(($urandom_range(0, 299) == 0), 1'($urandom), rb, 1'($urandom), ra,
                 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        idle(int'(LAT) + 2);
        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
